// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial a - b - bin, LSB first, start/busy/done handshake
module serial_full_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_br;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_br_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   // Single full-subtractor cell fed from the operand shift registers
   assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
   assign w_last    = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
   assign w_accept  = start && (r_state != RUN);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = start ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_nxt;
            r_br  <= w_br_nxt;
            r_cnt <= r_cnt + 1'b1;
            // Outputs only move on completion so they stay stable through RUN
            if (w_last) begin
               r_diff <= w_res_nxt;
               r_bout <= w_br_nxt;
            end
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - directed vectors and back-to-back scoreboard for serial_full_subtractor
module tb_serial_full_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       bin = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   int n_pass = 0;
   int n_total = 0;
   int busy_seen = 0;
   int done_seen = 0;

   serial_full_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Counts negedges from the cycle after the call until done, bounded
   task automatic wait_done(output int lat);
      lat = 0;
      repeat (40) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
   endtask

   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        output int lat, output int nbusy);
      int b0;
      @(posedge clk); #1;
      start = 1'b1; a = ta; b = tb_v; bin = tbin;
      b0 = busy_seen;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      wait_done(lat);
      nbusy = busy_seen - b0;
   endtask

   initial begin
      int lat, nbusy, b0, d0;
      logic [8:0] e_new, e_prev;
      logic [7:0] ra, rb;
      logic       rbin;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bout", 32'(bout), 32'd0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, nbusy);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
         check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'd8);
         check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
         check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      end

      // start re-asserted with a different operand in the 3rd busy cycle must be ignored
      @(posedge clk); #1;
      start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
      b0 = busy_seen;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(posedge clk); #1 start = 1'b0;
      wait_done(lat);
      check("ignore_done", 32'(done), 32'd1);
      check("ignore_busy_cycles", 32'(busy_seen - b0), 32'd8);
      check("ignore_diff", 32'(diff), 32'h0F);
      check("ignore_bout", 32'(bout), 32'd0);
      @(negedge clk);

      // reset in the 4th busy cycle discards the operation
      @(posedge clk); #1;
      start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      d0 = done_seen;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_bout", 32'(bout), 32'd0);
      repeat (12) @(negedge clk);
      check("midrst_no_done", 32'(done_seen - d0), 32'd0);
      do_op(8'h20, 8'h05, 1'b1, lat, nbusy);
      check("after_rst_latency", 32'(lat), 32'd9);
      check("after_rst_diff", 32'(diff), 32'h1A);
      check("after_rst_bout", 32'(bout), 32'd0);
      @(negedge clk);

      // start held high: back-to-back operations with no idle gap
      b0 = busy_seen;
      e_prev = '0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         start = 1'b1; a = ra; b = rb; bin = rbin;
         e_new = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
         @(negedge clk);
         if (i > 0) begin
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_result", 32'({bout, diff}), 32'(e_prev));
         end
         e_prev = e_new;
         repeat (8) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         end
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("b2b_last_done", 32'(done), 32'd1);
      check("b2b_last_result", 32'({bout, diff}), 32'(e_prev));
      check("b2b_busy_cycles", 32'(busy_seen - b0), 32'd8000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
